simplerisc_fetch_unit: RTL and testbench



---
 rtl/simplerisc_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_simplerisc_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simplerisc_fetch_unit.sv
// rtl/simplerisc_fetch_unit.sv - SimpleRisc instruction-fetch stage with request limiter, pending-PC FIFO and 2-entry instruction queue
module simplerisc_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] PC_STEP         = 32'd4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Branch_PC,
    input  logic        IsBranchTaken,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        If_Valid,
    output logic [31:0] If_Instr,
    output logic [31:0] If_PC
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;

    // Addresses granted but not yet answered, in request order
    logic [31:0] pend_pc [2];
    logic        pend_wr;
    logic        pend_rd;
    logic [1:0]  outstanding;

    // Instruction queue feeding operand fetch
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        q_wr;
    logic        q_rd;
    logic [1:0]  q_count;

    // Wrong-path responses still to be dropped
    logic [1:0]  discard;

    logic        grant;
    logic        resp_run;
    logic        pop;
    logic [2:0]  in_flight;
    logic [1:0]  redirect_discard;
    logic [1:0]  discard_dec;
    logic [1:0]  discard_load;

    assign grant     = imem_req & imem_gnt;
    assign resp_run  = imem_rvalid & (state == S_RUN);
    assign pop       = If_Valid & ~Stall;
    assign in_flight = {1'b0, outstanding} + {1'b0, q_count};

    // A request granted in the redirect cycle is still in flight; a response in that cycle is already gone
    assign redirect_discard = outstanding + 2'(grant) - 2'(imem_rvalid);
    assign discard_dec      = discard - 2'(imem_rvalid && (discard != 2'd0));
    assign discard_load     = (state == S_FLUSH) ? discard_dec :
                              (state == S_RUN)   ? redirect_discard : 2'd0;

    assign imem_addr = fetch_pc;
    assign If_Valid  = (q_count != 2'd0);
    assign If_Instr  = q_instr[q_rd];
    assign If_PC     = q_pc[q_rd];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: boot lasts one cycle, flush lasts until every wrong-path response is dropped
    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:  state_next = S_RUN;
            S_RUN: begin
                if (IsBranchTaken && (redirect_discard != 2'd0)) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (discard_dec == 2'd0) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_BOOT;
        endcase
    end

    // Output logic: request only while running and under the in-flight limit
    always_comb begin
        imem_req = 1'b0;
        if (state == S_RUN && in_flight < 3'(MAX_OUTSTANDING)) begin
            imem_req = 1'b1;
        end
    end

    // Fetch PC: redirect wins, otherwise advance on every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (IsBranchTaken) begin
            fetch_pc <= Branch_PC;
        end else if (grant) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // Pending-PC FIFO and outstanding count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_pc[0]  <= 32'h0;
            pend_pc[1]  <= 32'h0;
            pend_wr     <= 1'b0;
            pend_rd     <= 1'b0;
            outstanding <= 2'd0;
        end else if (IsBranchTaken) begin
            pend_wr     <= 1'b0;
            pend_rd     <= 1'b0;
            outstanding <= 2'd0;
        end else begin
            if (grant) begin
                pend_pc[pend_wr] <= fetch_pc;
                pend_wr          <= ~pend_wr;
            end
            if (resp_run) begin
                pend_rd <= ~pend_rd;
            end
            outstanding <= outstanding + 2'(grant) - 2'(resp_run);
        end
    end

    // Instruction queue: push on in-run response, pop when operand fetch accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                q_pc[i]    <= 32'h0;
                q_instr[i] <= 32'h0;
            end
            q_wr    <= 1'b0;
            q_rd    <= 1'b0;
            q_count <= 2'd0;
        end else if (IsBranchTaken) begin
            q_wr    <= 1'b0;
            q_rd    <= 1'b0;
            q_count <= 2'd0;
        end else begin
            if (resp_run) begin
                q_pc[q_wr]    <= pend_pc[pend_rd];
                q_instr[q_wr] <= imem_rdata;
                q_wr          <= ~q_wr;
            end
            if (pop) begin
                q_rd <= ~q_rd;
            end
            q_count <= q_count + 2'(resp_run) - 2'(pop);
        end
    end

    // Discard counter: loaded on redirect, counts down on each dropped response while flushing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard <= 2'd0;
        end else if (IsBranchTaken) begin
            discard <= discard_load;
        end else if (state == S_FLUSH) begin
            discard <= discard_dec;
        end
    end

endmodule

// File: tb/tb_simplerisc_fetch_unit.sv
// tb/tb_simplerisc_fetch_unit.sv - self-checking bench for simplerisc_fetch_unit
module tb_simplerisc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] Branch_PC;
    logic        IsBranchTaken;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        If_Valid;
    logic [31:0] If_Instr;
    logic [31:0] If_PC;

    simplerisc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Branch_PC    (Branch_PC),
        .IsBranchTaken(IsBranchTaken),
        .Stall        (Stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .If_Valid     (If_Valid),
        .If_Instr     (If_Instr),
        .If_PC        (If_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] g_q   [$];
    logic        resp_hold   = 1'b0;
    logic        log_grants  = 1'b0;
    logic        watch_first = 1'b0;
    logic [31:0] first_pc    = 32'hDEAD_BEEF;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] bpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the negedge: memory model plus scoreboard
    task automatic drive(input logic br, input logic [31:0] bpc, input logic st);
        logic [31:0] e;
        IsBranchTaken = br;
        Branch_PC     = bpc;
        Stall         = st;
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        if (mem_q.size() > 0 && !resp_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_q[0]);
            void'(mem_q.pop_front());
        end
        if (imem_req && imem_gnt) begin
            mem_q.push_back(imem_addr);
            if (!br) exp_q.push_back(imem_addr);
            if (log_grants) g_q.push_back(imem_addr);
        end
        if (br) begin
            exp_q.delete();
        end else if (If_Valid && !st) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h with nothing expected", If_PC);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", If_PC, e);
                chk("sb_instr", If_Instr, instr_of(e));
                if (watch_first) begin
                    first_pc    = If_PC;
                    watch_first = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc(input logic br, input logic [31:0] bpc, input logic st);
        @(negedge clk);
        drive(br, bpc, st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC,  1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h8};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hC};

        rst_n         = 1'b0;
        Branch_PC     = 32'h0;
        IsBranchTaken = 1'b0;
        Stall         = 1'b0;
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(If_Valid), 32'h0);
        chk("rst_instr", If_Instr, 32'h0);
        chk("rst_pc", If_PC, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        chk("boot_req", 32'(imem_req), 32'h0);

        // Startup sequence from the vector table
        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].br, vecs[i].bpc, vecs[i].st);
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(If_Valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) chk($sformatf("vec%0d_pc", i), If_PC, vecs[i].e_pc);
        end

        // Stall with the queue filling up
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            if (i >= 1) begin
                chk("stall_valid", 32'(If_Valid), 32'h1);
                chk("stall_pc", If_PC, 32'h10);
            end
            if (i >= 2) chk("stall_req", 32'(imem_req), 32'h0);
        end
        repeat (8) cyc(1'b0, 32'h0, 1'b0);

        // Redirect with two requests outstanding
        resp_hold = 1'b1;
        repeat (8) cyc(1'b0, 32'h0, 1'b0);
        chk("pre_redir_req", 32'(imem_req), 32'h0);
        chk("pre_redir_valid", 32'(If_Valid), 32'h0);
        chk("pre_redir_outstanding", 32'(mem_q.size()), 32'h2);
        cyc(1'b1, 32'h100, 1'b0);
        resp_hold   = 1'b0;
        watch_first = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        chk("redir_valid", 32'(If_Valid), 32'h0);
        chk("flush_req0", 32'(imem_req), 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("flush_req1", 32'(imem_req), 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("resume_req", 32'(imem_req), 32'h1);
        chk("resume_addr", imem_addr, 32'h100);
        repeat (6) cyc(1'b0, 32'h0, 1'b0);
        chk("first_pc_after_redir", first_pc, 32'h100);

        // Redirect coinciding with a grant and a response
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (imem_req && !If_Valid && mem_q.size() == 1) begin
                found = 1'b1;
                drive(1'b1, 32'h200, 1'b0);
            end else begin
                drive(1'b0, 32'h0, 1'b0);
            end
        end
        chk("same_cycle_found", 32'(found), 32'h1);
        cyc(1'b0, 32'h0, 1'b0);
        chk("same_cycle_valid", 32'(If_Valid), 32'h0);
        chk("same_cycle_flush_req", 32'(imem_req), 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("same_cycle_resume_req", 32'(imem_req), 32'h1);
        chk("same_cycle_resume_addr", imem_addr, 32'h200);
        repeat (6) cyc(1'b0, 32'h0, 1'b0);

        // PC wrap at the top of the address space
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        g_q.delete();
        log_grants = 1'b1;
        repeat (10) cyc(1'b0, 32'h0, 1'b0);
        log_grants = 1'b0;
        chk("wrap_count", 32'(g_q.size() >= 2), 32'h1);
        if (g_q.size() >= 2) begin
            chk("wrap_first", g_q[0], 32'hFFFF_FFFC);
            chk("wrap_second", g_q[1], 32'h0);
        end

        // Reset asserted in the middle of a flush
        resp_hold = 1'b1;
        repeat (6) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h300, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("mid_flush_req", 32'(imem_req), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_valid", 32'(If_Valid), 32'h0);
        chk("async_rst_instr", If_Instr, 32'h0);
        chk("async_rst_pc", If_PC, 32'h0);
        mem_q.delete();
        exp_q.delete();
        resp_hold     = 1'b0;
        IsBranchTaken = 1'b0;
        imem_rvalid   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        chk("reboot_req", 32'(imem_req), 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        repeat (8) cyc(1'b0, 32'h0, 1'b0);
        chk("final_drain_bounded", 32'(exp_q.size() <= 2), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
